// File: rtl/sram16_pkg.sv
// rtl/sram16_pkg.sv - shared types and constants for the 16-bit SRAM responder
package sram16_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    RECOVER
  } state_t;

  localparam int WAIT_W = 4;

  function automatic bit wait_ok(input int w);
    return (w >= 1) && (w <= 15);
  endfunction

endpackage

// File: rtl/sram16_resp_if.sv
// rtl/sram16_resp_if.sv - device-side request/acknowledge bus between arbiter and responder
interface sram16_resp_if;
  logic [31:0] dev_addr;
  logic [31:0] dev_wdata;
  logic [3:0]  dev_be;
  logic        dev_wr;
  logic        dev_req;
  logic        dev_ack;
  logic [31:0] dev_rdata;

  modport master (
    output dev_addr, dev_wdata, dev_be, dev_wr, dev_req,
    input  dev_ack, dev_rdata
  );

  modport slave (
    input  dev_addr, dev_wdata, dev_be, dev_wr, dev_req,
    output dev_ack, dev_rdata
  );
endinterface

// File: rtl/sram16_resp.sv
// rtl/sram16_resp.sv - executes one device-bus read/write at a time on an async 16-bit SRAM
module sram16_resp
  import sram16_pkg::*;
#(
  parameter int ADDR_W  = 18,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              dev_clk,
  input  logic              dev_rst,
  sram16_resp_if.slave      dev,
  output logic [ADDR_W-1:0] sram_a,
  output logic [15:0]       sram_dq_o,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  if (!wait_ok(RD_WAIT)) begin : g_bad_rd_wait
    $error("RD_WAIT must be in 1..15");
  end
  if (!wait_ok(WR_WAIT)) begin : g_bad_wr_wait
    $error("WR_WAIT must be in 1..15");
  end

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] cnt, cnt_nxt;
  logic              lat_wr;
  logic [1:0]        lat_be;
  logic              accept, rd_cap;
  logic              op_wr;
  logic [1:0]        op_be;
  logic              active, in_access;
  logic              ce_n_nxt, oe_n_nxt, we_n_nxt, ub_n_nxt, lb_n_nxt, dq_oe_nxt, ack_nxt;
  logic              unused_bits;

  assign unused_bits = ^{dev.dev_addr[31:ADDR_W+1], dev.dev_addr[0],
                         dev.dev_wdata[31:16], dev.dev_be[3:2]};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    rd_cap    = 1'b0;
    case (state)
      IDLE: begin
        if (dev.dev_req) begin
          state_nxt = SETUP;
          accept    = 1'b1;
        end
      end
      SETUP: begin
        state_nxt = ACCESS;
        cnt_nxt   = lat_wr ? WAIT_W'(WR_WAIT) : WAIT_W'(RD_WAIT);
      end
      ACCESS: begin
        cnt_nxt = cnt - WAIT_W'(1);
        if (cnt == WAIT_W'(1)) begin
          state_nxt = HOLD;
          rd_cap    = !lat_wr;
        end
      end
      HOLD:    state_nxt = RECOVER;
      // The arbiter still holds dev_req here, so it is deliberately not looked at.
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered, so they are derived from the state being entered.
  always_comb begin
    op_wr     = accept ? dev.dev_wr : lat_wr;
    op_be     = accept ? dev.dev_be[1:0] : lat_be;
    active    = (state_nxt == SETUP) || (state_nxt == ACCESS) || (state_nxt == HOLD);
    in_access = (state_nxt == ACCESS);
    ce_n_nxt  = 1'b1;
    oe_n_nxt  = 1'b1;
    we_n_nxt  = 1'b1;
    ub_n_nxt  = 1'b1;
    lb_n_nxt  = 1'b1;
    dq_oe_nxt = 1'b0;
    ack_nxt   = (state_nxt == HOLD);
    if (active) begin
      ce_n_nxt  = 1'b0;
      ub_n_nxt  = op_wr ? !op_be[1] : 1'b0;
      lb_n_nxt  = op_wr ? !op_be[0] : 1'b0;
      dq_oe_nxt = op_wr;
    end
    if (in_access) begin
      oe_n_nxt = op_wr;
      we_n_nxt = !(op_wr && (op_be != 2'b00));
    end
  end

  always_ff @(posedge dev_clk) begin
    if (dev_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      lat_wr        <= 1'b0;
      lat_be        <= 2'b00;
      sram_a        <= '0;
      sram_dq_o     <= '0;
      sram_dq_oe    <= 1'b0;
      sram_ce_n     <= 1'b1;
      sram_oe_n     <= 1'b1;
      sram_we_n     <= 1'b1;
      sram_ub_n     <= 1'b1;
      sram_lb_n     <= 1'b1;
      dev.dev_ack   <= 1'b0;
      dev.dev_rdata <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      sram_dq_oe  <= dq_oe_nxt;
      sram_ce_n   <= ce_n_nxt;
      sram_oe_n   <= oe_n_nxt;
      sram_we_n   <= we_n_nxt;
      sram_ub_n   <= ub_n_nxt;
      sram_lb_n   <= lb_n_nxt;
      dev.dev_ack <= ack_nxt;
      if (accept) begin
        lat_wr    <= dev.dev_wr;
        lat_be    <= dev.dev_be[1:0];
        sram_a    <= dev.dev_addr[ADDR_W:1];
        sram_dq_o <= dev.dev_wdata[15:0];
      end
      if (rd_cap) begin
        dev.dev_rdata <= {sram_dq_i, sram_dq_i};
      end
    end
  end

endmodule

// File: tb/tb_sram16_resp.sv
// tb/tb_sram16_resp.sv - scoreboard bench for sram16_resp with a behavioural async SRAM
module tb_sram16_resp;

  localparam int RDW = 2;
  localparam int WRW = 3;

  typedef struct {
    bit          wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          c0;
  } sb_item_t;

  logic        dev_clk;
  logic        dev_rst;
  logic [17:0] sram_a;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  sram16_resp_if dev_bus ();

  sram16_resp #(.ADDR_W(18), .RD_WAIT(RDW), .WR_WAIT(WRW)) dut (
    .dev_clk    (dev_clk),
    .dev_rst    (dev_rst),
    .dev        (dev_bus.slave),
    .sram_a     (sram_a),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_i  (sram_dq_i),
    .sram_dq_oe (sram_dq_oe),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_ub_n  (sram_ub_n),
    .sram_lb_n  (sram_lb_n)
  );

  logic [15:0] model_mem [0:4095];
  logic [15:0] ref_mem   [0:4095];
  sb_item_t    sb [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          edge_cnt = 0;
  int          last_ack_cyc = -10;
  logic [31:0] exp_last_rd = '0;
  bit          mon_en = 1'b0;
  bit          overlap_seen = 1'b0;

  initial dev_clk = 1'b0;
  always #5 dev_clk = ~dev_clk;
  always @(posedge dev_clk) edge_cnt <= edge_cnt + 1;

  always_comb sram_dq_i = (!sram_ce_n && !sram_oe_n) ? model_mem[sram_a[11:0]] : 16'h0000;

  always @(posedge dev_clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      if (!sram_lb_n) model_mem[sram_a[11:0]][7:0]  = sram_dq_o[7:0];
      if (!sram_ub_n) model_mem[sram_a[11:0]][15:8] = sram_dq_o[15:8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge dev_clk) begin
    if (sram_dq_oe && !sram_oe_n) overlap_seen = 1'b1;
  end

  // Expected strobe pattern is rebuilt from the phase of the oldest outstanding request.
  always @(negedge dev_clk) begin
    if (mon_en) begin
      int p, w;
      bit act, acc, hold, wr;
      logic [3:0] be;
      logic [6:0] exp_v;
      p = -1; w = 0; wr = 1'b0; be = 4'h0;
      if (sb.size() > 0 && edge_cnt >= sb[0].c0) begin
        p  = edge_cnt - sb[0].c0;
        wr = sb[0].wr;
        be = sb[0].be;
        w  = wr ? WRW : RDW;
      end
      act  = (p >= 1) && (p <= w + 2);
      acc  = (p >= 2) && (p <= w + 1);
      hold = (p == w + 2);
      exp_v = {!act, !(acc && !wr), !(acc && wr && (be[1:0] != 2'b00)),
               act ? (wr ? !be[1] : 1'b0) : 1'b1,
               act ? (wr ? !be[0] : 1'b0) : 1'b1,
               act && wr, hold};
      check("strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
                            sram_dq_oe, dev_bus.dev_ack}), 32'(exp_v));
      if (act) begin
        check("sram_a", 32'(sram_a), 32'(sb[0].addr[18:1]));
        if (wr) check("dq_o", 32'(sram_dq_o), 32'(sb[0].wdata[15:0]));
      end
      if (dev_bus.dev_ack) begin
        if (sb.size() == 0) begin
          check("spurious_ack", 32'd1, 32'd0);
        end else begin
          sb_item_t it;
          it = sb.pop_front();
          check("ack_cycle", 32'(edge_cnt), 32'(it.c0 + (it.wr ? WRW : RDW) + 2));
          check("rdata", dev_bus.dev_rdata, it.rdata);
        end
      end
    end
  end

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
    sb_item_t it;
    int word;
    bit got;
    @(posedge dev_clk); #1;
    dev_bus.dev_req   = 1'b1;
    dev_bus.dev_wr    = wr;
    dev_bus.dev_addr  = addr;
    dev_bus.dev_wdata = wdata;
    dev_bus.dev_be    = be;
    it.wr = wr; it.be = be; it.addr = addr; it.wdata = wdata;
    it.c0 = (last_ack_cyc == edge_cnt - 1) ? edge_cnt + 1 : edge_cnt;
    word = int'(addr[12:1]);
    if (wr) begin
      if (be[0]) ref_mem[word][7:0]  = wdata[7:0];
      if (be[1]) ref_mem[word][15:8] = wdata[15:8];
      it.rdata = exp_last_rd;
    end else begin
      it.rdata = {ref_mem[word], ref_mem[word]};
      exp_last_rd = it.rdata;
    end
    sb.push_back(it);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge dev_clk);
      if (dev_bus.dev_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("ack_timeout", 32'd0, 32'd1);
    last_ack_cyc = edge_cnt;
  endtask

  task automatic idle(input int n);
    @(posedge dev_clk); #1;
    dev_bus.dev_req = 1'b0;
    for (int i = 0; i < n; i++) @(posedge dev_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int acks;
    for (int i = 0; i < 4096; i++) begin
      model_mem[i] = 16'(i) ^ 16'hC3C3;
      ref_mem[i]   = 16'(i) ^ 16'hC3C3;
    end
    model_mem[12'h91A] = 16'hBEEF; ref_mem[12'h91A] = 16'hBEEF;
    model_mem[8]       = 16'h1234; ref_mem[8]       = 16'h1234;

    dev_rst = 1'b1;
    dev_bus.dev_req = 1'b0; dev_bus.dev_wr = 1'b0;
    dev_bus.dev_addr = '0; dev_bus.dev_wdata = '0; dev_bus.dev_be = '0;
    repeat (3) @(posedge dev_clk);
    @(negedge dev_clk);
    check("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
                              sram_dq_oe, dev_bus.dev_ack}), 32'b1111100);
    check("rst_rdata", dev_bus.dev_rdata, 32'h0);
    check("rst_sram_a", 32'(sram_a), 32'h0);
    check("rst_dq_o", 32'(sram_dq_o), 32'h0);
    @(posedge dev_clk); #1;
    dev_rst = 1'b0;
    mon_en = 1'b1;
    idle(1);

    issue(1'b0, 32'h0000_1234, 32'h0, 4'hF);
    idle(2);
    issue(1'b1, 32'h0000_0010, 32'h0000_A55A, 4'b0001);
    idle(1);
    check("mem_be0001", 32'(model_mem[8]), 32'h0000_125A);
    issue(1'b1, 32'h0000_0020, 32'h0000_FFFF, 4'b0000);
    idle(1);
    check("mem_be0000", 32'(model_mem[16]), 32'(16'h0010 ^ 16'hC3C3));

    issue(1'b0, 32'h0000_0040, 32'h0, 4'hF);
    issue(1'b1, 32'h0000_0040, 32'h0000_7E81, 4'b0011);
    issue(1'b0, 32'h0000_0040, 32'h0, 4'hF);
    idle(2);
    check("b2b_mem", 32'(model_mem[32]), 32'h0000_7E81);

    for (int k = 0; k < 12; k++) begin
      issue(1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 7) * 2),
            $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
    end
    issue(1'b0, 32'h0000_1234, 32'h0, 4'hF);
    idle(3);

    // Reset lands in the last access cycle of a read; nothing may complete.
    mon_en = 1'b0;
    @(posedge dev_clk); #1;
    dev_bus.dev_req = 1'b1; dev_bus.dev_wr = 1'b0; dev_bus.dev_addr = 32'h80;
    @(posedge dev_clk); #1;
    dev_bus.dev_req = 1'b0;
    @(posedge dev_clk); #1;
    @(posedge dev_clk); #1;
    dev_rst = 1'b1;
    @(posedge dev_clk); #1;
    dev_rst = 1'b0;
    @(negedge dev_clk);
    check("midrst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
                                 sram_dq_oe, dev_bus.dev_ack}), 32'b1111100);
    check("midrst_rdata", dev_bus.dev_rdata, 32'h0);
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge dev_clk);
      if (dev_bus.dev_ack) acks++;
    end
    check("midrst_no_ack", 32'(acks), 32'd0);
    exp_last_rd = '0;
    mon_en = 1'b1;
    issue(1'b0, 32'h0000_1234, 32'h0, 4'hF);
    idle(3);

    check("sb_empty", 32'(sb.size()), 32'd0);
    check("no_overlap", 32'(overlap_seen), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
